// File: rtl/axi_lite_reg_checker.sv
// AXI4-Lite master that writes a pattern to each register of a slave bank, reads it back and compares.
// Reports pass/timeout, a saturating error count and the first failing register index.
module axi_lite_reg_checker #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    TIMEOUT    = 255
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [DATA_WIDTH-1:0]     seed,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [7:0]                err_count,
  output logic [7:0]                first_fail,
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  localparam int         STEP   = DATA_WIDTH / 8;
  localparam logic [7:0] LAST   = 8'(NUM_REGS - 1);
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA, S_FINISH} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              idx_q, idx_d;
  logic [1:0]              mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   seed_q, seed_d;
  logic [15:0]             to_cnt_q, to_cnt_d;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [7:0]              err_q, err_d, first_q, first_d;
  logic                    pass_q, pass_d, tmo_q, tmo_d, busy_q, busy_d, done_q, done_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                    arvalid_q, arvalid_d, rready_q, rready_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic                    err_hit, tick, enter_write, aw_hs, w_hs;
  logic [1:0]              wr_mode;
  logic [DATA_WIDTH-1:0]   wr_seed;
  logic [7:0]              wr_idx;

  function automatic logic [DATA_WIDTH-1:0] pattern_f(input logic [1:0] m,
                                                      input logic [DATA_WIDTH-1:0] s,
                                                      input logic [7:0] idx);
    logic [DATA_WIDTH-1:0] sum;
    sum = s + DATA_WIDTH'(idx);
    case (m)
      2'd0:    return sum;
      2'd1:    return {{(DATA_WIDTH-1){1'b0}}, 1'b1} << (idx % 8'(DATA_WIDTH));
      2'd2:    return ~sum;
      default: return s;
    endcase
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] addr_f(input logic [7:0] idx);
    return BASE_ADDR + ADDR_WIDTH'(idx) * ADDR_WIDTH'(STEP);
  endfunction

  always_comb begin
    state_d   = state_q;   idx_d    = idx_q;    mode_d   = mode_q;   seed_d  = seed_q;
    to_cnt_d  = to_cnt_q;  aw_done_d = aw_done_q; w_done_d = w_done_q;
    err_d     = err_q;     first_d  = first_q;  pass_d   = pass_q;   tmo_d   = tmo_q;
    busy_d    = busy_q;    done_d   = 1'b0;
    awvalid_d = awvalid_q; wvalid_d = wvalid_q; bready_d = bready_q;
    arvalid_d = arvalid_q; rready_d = rready_q; addr_d   = addr_q;   wdata_d = wdata_q;
    err_hit   = 1'b0;      tick     = 1'b0;     enter_write = 1'b0;
    wr_mode   = mode_q;    wr_seed  = seed_q;   wr_idx   = idx_q;
    aw_hs     = awvalid_q & M_AXI_AWREADY;
    w_hs      = wvalid_q & M_AXI_WREADY;

    case (state_q)
      S_IDLE: if (start) begin
        mode_d = mode;  seed_d = seed;  idx_d = '0;
        err_d  = '0;    first_d = '0;   pass_d = 1'b0;  tmo_d = 1'b0;  busy_d = 1'b1;
        enter_write = 1'b1;  wr_mode = mode;  wr_seed = seed;  wr_idx = '0;
      end
      S_WRITE: begin
        // AW and W are tracked separately; the slave may take them in either order
        if (aw_hs) begin awvalid_d = 1'b0; aw_done_d = 1'b1; end
        if (w_hs)  begin wvalid_d  = 1'b0; w_done_d  = 1'b1; end
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          state_d = S_WRESP;  bready_d = 1'b1;
        end else tick = 1'b1;
      end
      S_WRESP: if (M_AXI_BVALID) begin
        bready_d = 1'b0;  arvalid_d = 1'b1;  state_d = S_RADDR;
        err_hit  = (M_AXI_BRESP != 2'b00);
      end else tick = 1'b1;
      S_RADDR: if (M_AXI_ARREADY) begin
        arvalid_d = 1'b0;  rready_d = 1'b1;  state_d = S_RDATA;
      end else tick = 1'b1;
      S_RDATA: if (M_AXI_RVALID) begin
        rready_d = 1'b0;
        err_hit  = (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != wdata_q);
        if (idx_q == LAST) state_d = S_FINISH;
        else begin
          idx_d = idx_q + 8'd1;  enter_write = 1'b1;  wr_idx = idx_q + 8'd1;
        end
      end else tick = 1'b1;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (enter_write) begin
      state_d  = S_WRITE;  awvalid_d = 1'b1;  wvalid_d = 1'b1;
      aw_done_d = 1'b0;    w_done_d  = 1'b0;
      addr_d   = addr_f(wr_idx);
      wdata_d  = pattern_f(wr_mode, wr_seed, wr_idx);
    end

    if (err_hit) begin
      if (err_q == 8'd0)  first_d = idx_q;
      if (err_q != 8'hFF) err_d   = err_q + 8'd1;
    end

    // A hung slave is abandoned by dropping every valid/ready mid-handshake
    if (tick) begin
      if (to_cnt_q == TO_LIM) begin
        tmo_d = 1'b1;  state_d = S_FINISH;
        awvalid_d = 1'b0; wvalid_d = 1'b0; bready_d = 1'b0; arvalid_d = 1'b0; rready_d = 1'b0;
        if (err_q == 8'd0) first_d = idx_q;
      end else to_cnt_d = to_cnt_q + 16'd1;
    end

    if (state_d != state_q) to_cnt_d = '0;

    if (state_d == S_FINISH && state_q != S_FINISH) begin
      done_d = 1'b1;  busy_d = 1'b0;
      pass_d = (err_d == 8'd0) && !tmo_d;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_IDLE; idx_q    <= '0;   mode_q   <= '0;   seed_q  <= '0;
      to_cnt_q  <= '0;     aw_done_q <= 1'b0; w_done_q <= 1'b0;
      err_q     <= '0;     first_q  <= '0;   pass_q   <= 1'b0; tmo_q   <= 1'b0;
      busy_q    <= 1'b0;   done_q   <= 1'b0;
      awvalid_q <= 1'b0;   wvalid_q <= 1'b0; bready_q <= 1'b0;
      arvalid_q <= 1'b0;   rready_q <= 1'b0; addr_q   <= '0;   wdata_q <= '0;
    end else begin
      state_q   <= state_d;   idx_q    <= idx_d;     mode_q   <= mode_d;   seed_q  <= seed_d;
      to_cnt_q  <= to_cnt_d;  aw_done_q <= aw_done_d; w_done_q <= w_done_d;
      err_q     <= err_d;     first_q  <= first_d;   pass_q   <= pass_d;   tmo_q   <= tmo_d;
      busy_q    <= busy_d;    done_q   <= done_d;
      awvalid_q <= awvalid_d; wvalid_q <= wvalid_d;  bready_q <= bready_d;
      arvalid_q <= arvalid_d; rready_q <= rready_d;  addr_q   <= addr_d;   wdata_q <= wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = tmo_q;
  assign err_count     = err_q;
  assign first_fail    = first_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_reg_checker.sv
// Bench for axi_lite_reg_checker: configurable memory slave (delays, error responses, stuck bit, hung AR)
// plus a per-register reference model of the expected sweep outcome.
module tb_axi_lite_reg_checker;
  localparam int NR = 4;
  localparam int TO = 16;

  logic        ACLK = 1'b0, ARESET = 1'b1, start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] seed = 32'd0;
  logic        busy, done, pass, timeout;
  logic [7:0]  err_count, first_fail;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic        awready, wready, bvalid, arready, rvalid, ar_hung;
  logic [1:0]  b_resp, r_resp;
  logic [31:0] r_d;

  axi_lite_reg_checker #(.NUM_REGS(NR), .TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .mode(mode), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_fail(first_fail),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(b_resp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(r_d), .M_AXI_RRESP(r_resp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  // ---------------- slave ----------------
  int cfg_maxd = 0, cfg_bresp = -1, cfg_rresp = -1, cfg_stuck = -1, cfg_hang = -1;
  logic [31:0] mem [0:3];
  logic        aw_got, w_got, b_pend, r_pend, aw_f, w_f;
  logic [31:0] aw_a, w_dq, wr_a, wr_d;
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;

  function automatic int rnd_d();
    return (cfg_maxd == 0) ? 0 : int'($urandom_range(cfg_maxd, 0));
  endfunction

  assign ar_hung = (cfg_hang >= 0) && (ARADDR[3:2] == cfg_hang[1:0]);
  assign awready = !aw_got && (aw_wait == 0 || cfg_maxd == 0);
  assign wready  = !w_got  && (w_wait  == 0 || cfg_maxd == 0);
  assign bvalid  = b_pend  && (b_wait  == 0 || cfg_maxd == 0);
  assign arready = !r_pend && !ar_hung && (ar_wait == 0 || cfg_maxd == 0);
  assign rvalid  = r_pend  && (r_wait  == 0 || cfg_maxd == 0);
  assign aw_f    = AWVALID && awready;
  assign w_f     = WVALID && wready;
  assign wr_a    = aw_f ? AWADDR : aw_a;
  assign wr_d    = w_f ? WDATA : w_dq;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
      aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
      aw_a <= 0; w_dq <= 0; b_resp <= 0; r_resp <= 0; r_d <= 0;
    end else begin
      if (AWVALID && !aw_got && aw_wait != 0) aw_wait <= aw_wait - 1;
      if (WVALID && !w_got && w_wait != 0)    w_wait  <= w_wait - 1;
      if (aw_f) begin aw_a <= AWADDR; aw_wait <= rnd_d(); end
      if (w_f)  begin w_dq <= WDATA;  w_wait  <= rnd_d(); end
      if ((aw_got || aw_f) && (w_got || w_f)) begin
        mem[wr_a[3:2]] <= wr_d;
        b_pend <= 1; b_wait <= rnd_d();
        b_resp <= (cfg_bresp >= 0 && wr_a[3:2] == cfg_bresp[1:0]) ? 2'b10 : 2'b00;
        aw_got <= 0; w_got <= 0;
      end else begin
        aw_got <= aw_got || aw_f; w_got <= w_got || w_f;
      end
      if (b_pend && b_wait != 0) b_wait <= b_wait - 1;
      if (bvalid && BREADY) b_pend <= 0;
      if (ARVALID && ar_wait != 0) ar_wait <= ar_wait - 1;
      if (ARVALID && arready) begin
        r_pend <= 1; r_wait <= rnd_d(); ar_wait <= rnd_d();
        r_d <= mem[ARADDR[3:2]] &
               ~((cfg_stuck >= 0 && ARADDR[3:2] == cfg_stuck[1:0]) ? 32'h10 : 32'h0);
        r_resp <= (cfg_rresp >= 0 && ARADDR[3:2] == cfg_rresp[1:0]) ? 2'b10 : 2'b00;
      end
      if (r_pend && r_wait != 0) r_wait <= r_wait - 1;
      if (rvalid && RREADY) r_pend <= 0;
    end
  end

  // ---------------- monitors ----------------
  int n_aw = 0, n_w = 0, n_ar = 0, n_done = 0, n_arhi = 0;
  always @(posedge ACLK) begin
    if (aw_f) n_aw++;
    if (w_f) n_w++;
    if (ARVALID && arready) n_ar++;
    if (done) n_done++;
    if (ARVALID) n_arhi++;
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat_m(input logic [1:0] m, input logic [31:0] s, input int i);
    case (m)
      2'd0:    return s + 32'(i);
      2'd1:    return 32'h1 << i;
      2'd2:    return ~(s + 32'(i));
      default: return s;
    endcase
  endfunction

  task automatic run_sweep(input string nm, input logic [1:0] m, input logic [31:0] s,
                           input int maxd, input int be, input int rre, input int stk,
                           input int hang, input bit chk_lat, input bit restart);
    int e_err, e_first, cyc, aw0, w0, ar0, d0, hi0, nwr, nrd;
    bit e_to, seen;
    logic [31:0] p [4];
    logic [31:0] rd;
    cfg_maxd = maxd; cfg_bresp = be; cfg_rresp = rre; cfg_stuck = stk; cfg_hang = hang;
    e_err = 0; e_first = -1; e_to = 0; nwr = NR; nrd = NR;
    for (int i = 0; i < NR; i++) begin
      p[i] = pat_m(m, s, i);
      if (be == i) begin e_err++; if (e_first < 0) e_first = i; end
      if (hang == i) begin
        e_to = 1; if (e_first < 0) e_first = i; nwr = i + 1; nrd = i;
        break;
      end
      rd = p[i] & ~((stk == i) ? 32'h10 : 32'h0);
      if (rre == i || rd != p[i]) begin e_err++; if (e_first < 0) e_first = i; end
    end
    if (e_first < 0) e_first = 0;

    @(negedge ACLK);
    aw0 = n_aw; w0 = n_w; ar0 = n_ar; d0 = n_done; hi0 = n_arhi;
    mode = m; seed = s; start = 1'b1; cyc = 0; seen = 0;
    while (!seen && cyc < 3000) begin
      @(negedge ACLK); cyc++;
      start = restart && (cyc == 4);
      if (cyc == 2) begin mode = ~m; seed = $urandom; end
      if (cyc == 1) chk({nm, ":busy_awvalid"}, {30'b0, busy, AWVALID}, 32'd3);
      if (done) seen = 1;
    end
    start = 1'b0;
    chk({nm, ":done_seen"}, 32'(seen), 32'd1);
    if (chk_lat) chk({nm, ":latency"}, cyc, 4 * NR + 1);
    chk({nm, ":err_count"}, 32'(err_count), e_err);
    chk({nm, ":first_fail"}, 32'(first_fail), e_first);
    chk({nm, ":pass"}, 32'(pass), 32'(!e_to && e_err == 0));
    chk({nm, ":timeout"}, 32'(timeout), 32'(e_to));
    chk({nm, ":busy_at_done"}, 32'(busy), 0);
    repeat (3) @(negedge ACLK);
    chk({nm, ":done_pulses"}, n_done - d0, 1);
    chk({nm, ":aw_xfers"}, n_aw - aw0, nwr);
    chk({nm, ":w_xfers"}, n_w - w0, nwr);
    chk({nm, ":ar_xfers"}, n_ar - ar0, nrd);
    if (hang < 0) begin
      for (int i = 0; i < NR; i++) chk({nm, ":mem"}, mem[i], p[i]);
    end else begin
      chk({nm, ":arvalid_cycles"}, n_arhi - hi0, TO);
      chk({nm, ":arvalid_dropped"}, 32'(ARVALID), 0);
    end
  endtask

  initial begin
    int nb, k, d0;
    logic pb;
    repeat (3) @(negedge ACLK);
    chk("reset:status", {busy, done, pass, timeout, err_count, first_fail}, 0);
    chk("reset:axi", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("idle:status", {busy, done, pass, timeout, err_count, first_fail}, 0);

    run_sweep("zero_wait", 2'd0, 32'h0101FFFF, 0, -1, -1, -1, -1, 1, 1);
    chk("zero_wait:last_word", mem[3], 32'h01020002);
    run_sweep("stuck_bit", 2'd3, 32'hDEAD0011, 0, -1, -1, 2, -1, 1, 0);
    run_sweep("rand_delay", 2'd1, $urandom, 5, -1, -1, -1, -1, 0, 0);
    run_sweep("slverr", 2'd2, $urandom, 0, 1, 3, -1, -1, 1, 0);
    run_sweep("ar_hang", 2'd0, $urandom, 0, -1, -1, -1, 0, 0, 0);

    // Async reset landing in WRESP of register 2
    cfg_maxd = 0; cfg_bresp = -1; cfg_rresp = -1; cfg_stuck = -1; cfg_hang = -1;
    @(negedge ACLK);
    d0 = n_done; mode = 2'd0; seed = $urandom; start = 1'b1;
    @(negedge ACLK); start = 1'b0;
    nb = 0; k = 0; pb = 1'b0;
    while (nb < 3 && k < 200) begin
      if (BREADY && !pb) nb++;
      pb = BREADY;
      if (nb < 3) begin @(negedge ACLK); k++; end
    end
    chk("rst_mid:reached_wresp2", nb, 3);
    #2 ARESET = 1'b1;
    #1;
    chk("rst_mid:status_zero", {busy, done, pass, timeout, err_count, first_fail}, 0);
    chk("rst_mid:axi_zero", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
    @(negedge ACLK); ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
    chk("rst_mid:no_done", n_done - d0, 0);
    run_sweep("after_reset", 2'd0, $urandom, 0, -1, -1, -1, -1, 1, 0);

    for (int r = 0; r < 6; r++)
      run_sweep("random", 2'($urandom_range(3, 0)), $urandom, 5,
                int'($urandom_range(4, 0)) - 1, int'($urandom_range(4, 0)) - 1, -1, -1, 0, r[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule

// File: doc/axi_lite_reg_checker.md
# axi_lite_reg_checker

Synthesizable AXI4-Lite master that runs a write/read-back/compare sweep over a parametrised bank of 32-bit-aligned slave registers. It sits between a control source (PS GPIO or debug register) and any AXI4-Lite slave in the camera-car fabric. It replaces simulation-only register checks with an in-system self-test that reports pass/fail, error counts and the first failing register.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (32 or 64)
- NUM_REGS, 4, registers swept (1..256)
- BASE_ADDR, 0, address of register 0; register i at BASE_ADDR + i*(DATA_WIDTH/8)
- TIMEOUT, 255, max cycles waiting for any single handshake (1..65535)

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a sweep when idle
- mode  in  2  pattern: 0 = seed+i, 1 = walking one (1<<(i mod DATA_WIDTH)), 2 = ~(seed+i), 3 = seed (constant)
- seed  in  DATA_WIDTH  pattern seed, sampled with start
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end
- pass  out  1  last sweep clean; held until next start
- timeout  out  1  last sweep aborted on timeout; held until next start
- err_count  out  8  mismatches + non-OKAY responses, saturating at 255
- first_fail  out  8  index of first failing register; valid when pass=0 and err_count>0
- M_AXI_AW*/W*/B*/AR*/R*  standard AXI4-Lite master channels; AWPROT=ARPROT=0, WSTRB all ones

## Operation
- States: IDLE, WRITE, WRESP, RADDR, RDATA, FINISH.
- IDLE: start=1 latches mode and seed, clears err_count, first_fail, pass and timeout, sets i=0, and enters WRITE. start while busy=1 is ignored.
- WRITE: AWVALID and WVALID asserted together with addr(i) and pattern(i).
  - Each valid drops independently on its own handshake.
  - Leave only when both AW and W are accepted (same or different cycles).
- WRESP: BREADY=1. On BVALID, BRESP != OKAY counts one error; go to RADDR.
- RADDR: ARVALID=1 with addr(i). On ARREADY go to RDATA.
- RDATA: RREADY=1. On RVALID, count one error if RRESP != OKAY or RDATA != pattern(i). Both failing in one beat counts one error.
- Per-register error accounting: at most 2 errors per register (write response, read beat). The first error of a sweep records first_fail=i.
- After RDATA, if i < NUM_REGS-1: increment i and go to WRITE; otherwise go to FINISH.
- FINISH: pulse done, set pass = (err_count==0 && !timeout), return to IDLE.
- Arithmetic: pattern computed modulo 2^DATA_WIDTH; addr(i) computed modulo 2^ADDR_WIDTH (wrap permitted).
- Timeout: a counter clears on entry to each of WRITE/WRESP/RADDR/RDATA and increments every cycle the state's handshake is not complete.
  - Reaching TIMEOUT sets timeout=1, deasserts all valid/ready outputs and goes to FINISH.
  - Dropping a valid this way is a deliberate protocol violation, accepted only for a hung slave.
  - If no error was recorded before the timeout, first_fail is set to i.

## Timing
- Reset: every output is 0; the FSM is in IDLE. Assertion mid-sweep aborts immediately, with no done pulse.
- start in cycle N: busy=1 and AWVALID=WVALID=1 from cycle N+1.
- Zero-wait slave: 4 cycles per register (WRITE, WRESP, RADDR, RDATA). The done pulse follows the last RDATA by one cycle (FINISH). The sweep takes 4*NUM_REGS+1 cycles after start.
- busy falls in the same cycle done is high. pass, timeout, err_count and first_fail are stable when done=1.
- All AXI outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Zero-wait memory slave, NUM_REGS=4, mode=0, seed=0x0101FFFF: writes 0x0101FFFF..0x01020002 to 0x0,4,8,C -> done at start+17, pass=1, err_count=0.
- Slave with bit 4 of register 2 stuck at 0, mode=3, seed=0xDEAD0011: RDATA 0xDEAD0001 -> pass=0, err_count=1, first_fail=2.
- Slave with random 0-5 cycle AWREADY/WREADY/BVALID/ARREADY/RVALID delays (AW and W accepted in different cycles), mode=1: no duplicate transfers; walking one 0x1,0x2,0x4,0x8 read back; pass=1.
- Slave returning BRESP=SLVERR on register 1 and RRESP=SLVERR on register 3 -> err_count=2, first_fail=1, pass=0.
- TIMEOUT=16, slave never asserts ARREADY on register 0 -> ARVALID drops after 16 cycles, timeout=1, pass=0, first_fail=0, done pulses once.
- ARESET pulsed during WRESP of register 2 -> all outputs 0 immediately. A second start pulse issued while busy is ignored. A fresh start after reset completes a clean sweep.
